// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
//  Module  : mem_arbiter_pkg
//  Brief   : Shared rw_flag encodings and arbiter FSM state type.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

   localparam logic [1:0] c_rw_idle  = 2'b00;
   localparam logic [1:0] c_rw_read  = 2'b01;
   localparam logic [1:0] c_rw_write = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_RESP  = 2'd2
   } arb_state_t;

   // 2'b11 is not a legal request and must never win arbitration.
   function automatic logic rw_pending(input logic [1:0] rw);
      return (rw == c_rw_read) || (rw == c_rw_write);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_rr.sv
// ============================================================================
//  Module  : mem_arbiter_rr
//  Brief   : Two-way round-robin grant selection, purely combinational.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter_rr (
   input  logic [1:0] i_pending,
   input  logic       i_last_grant,
   output logic       o_grant,
   output logic       o_any
);

   assign o_any = |i_pending;

   // On a tie the channel that did not win last time goes next.
   always_comb begin
      o_grant = i_pending[1];
      if (&i_pending) begin
         o_grant = ~i_last_grant;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module  : mem_arbiter
//  Brief   : Serialises the D-cache (ch0) and I-cache (ch1) onto one RAM port.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int   ADDR_W      = 32,
   parameter int   DATA_W      = 32,
   parameter logic FIRST_GRANT = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          mem_rwe_i,
   input  logic [2*ADDR_W-1:0] mem_addr_i,
   input  logic [2*DATA_W-1:0] mem_data_i,
   input  logic [7:0]          mem_sel_i,
   output logic [2*DATA_W-1:0] mem_data_o,
   output logic [1:0]          mem_busy_o,
   output logic [1:0]          mem_done_o,
   output logic                ram_req_o,
   output logic                ram_we_o,
   output logic [ADDR_W-1:0]   ram_addr_o,
   output logic [DATA_W-1:0]   ram_wdata_o,
   output logic [3:0]          ram_wmask_o,
   input  logic [DATA_W-1:0]   ram_rdata_i,
   input  logic                ram_ack_i
);

   logic [1:0]        w_pending;
   logic [1:0]        w_is_write;
   logic [ADDR_W-1:0] w_addr  [2];
   logic [DATA_W-1:0] w_wdata [2];
   logic [3:0]        w_sel   [2];
   logic              w_grant;
   logic              w_any;

   arb_state_t        r_state;
   logic              r_last_grant;
   logic              r_grant;
   logic              r_req;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [3:0]        r_wmask;
   logic [DATA_W-1:0] r_rdata [2];
   logic [1:0]        r_done;

   for (genvar c = 0; c < 2; c++) begin : g_ch
      assign w_pending[c]  = rw_pending(mem_rwe_i[2*c +: 2]);
      assign w_is_write[c] = (mem_rwe_i[2*c +: 2] == c_rw_write);
      assign w_addr[c]     = mem_addr_i[c*ADDR_W +: ADDR_W];
      assign w_wdata[c]    = mem_data_i[c*DATA_W +: DATA_W];
      assign w_sel[c]      = mem_sel_i[4*c +: 4];
      assign mem_data_o[c*DATA_W +: DATA_W] = r_rdata[c];
   end

   mem_arbiter_rr u_rr (
      .i_pending    (w_pending),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_any        (w_any)
   );

   // Busy follows rw_flag combinationally; forced low while reset is held.
   assign mem_busy_o  = w_pending & ~r_done & {2{rst}};
   assign mem_done_o  = r_done;
   assign ram_req_o   = r_req;
   assign ram_we_o    = r_we;
   assign ram_addr_o  = r_addr;
   assign ram_wdata_o = r_wdata;
   assign ram_wmask_o = r_wmask;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ARB_IDLE;
         r_last_grant <= ~FIRST_GRANT;
         r_grant      <= 1'b0;
         r_req        <= 1'b0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_wmask      <= '0;
         r_done       <= '0;
         for (int c = 0; c < 2; c++) begin
            r_rdata[c] <= '0;
         end
      end else begin
         case (r_state)
            ARB_IDLE: begin
               r_done <= '0;
               if (w_any) begin
                  r_grant      <= w_grant;
                  r_last_grant <= w_grant;
                  r_we         <= w_is_write[w_grant];
                  r_addr       <= w_addr[w_grant];
                  r_wdata      <= w_wdata[w_grant];
                  r_wmask      <= w_sel[w_grant];
                  r_req        <= 1'b1;
                  r_state      <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (ram_ack_i) begin
                  r_req           <= 1'b0;
                  r_done[r_grant] <= 1'b1;
                  if (!r_we) begin
                     r_rdata[r_grant] <= ram_rdata_i;
                  end
                  r_state <= ARB_RESP;
               end
            end
            ARB_RESP: begin
               r_done  <= '0;
               r_state <= ARB_IDLE;
            end
            default: begin
               r_req   <= 1'b0;
               r_done  <= '0;
               r_state <= ARB_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
//  Module  : tb_mem_arbiter
//  Brief   : Self-checking bench for mem_arbiter with a behavioural RAM/arbiter model.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  rw_q  [2];
   logic [31:0] ad_q  [2];
   logic [31:0] wd_q  [2];
   logic [3:0]  sel_q [2];

   logic [3:0]  mem_rwe_i;
   logic [63:0] mem_addr_i;
   logic [63:0] mem_data_i;
   logic [7:0]  mem_sel_i;
   logic [63:0] mem_data_o;
   logic [1:0]  mem_busy_o;
   logic [1:0]  mem_done_o;
   logic        ram_req_o;
   logic        ram_we_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [3:0]  ram_wmask_o;
   logic [31:0] ram_rdata_i;
   logic        ram_ack_i;

   assign mem_rwe_i  = {rw_q[1], rw_q[0]};
   assign mem_addr_i = {ad_q[1], ad_q[0]};
   assign mem_data_i = {wd_q[1], wd_q[0]};
   assign mem_sel_i  = {sel_q[1], sel_q[0]};

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIRST_GRANT(1'b0)) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_rwe_i   (mem_rwe_i),
      .mem_addr_i  (mem_addr_i),
      .mem_data_i  (mem_data_i),
      .mem_sel_i   (mem_sel_i),
      .mem_data_o  (mem_data_o),
      .mem_busy_o  (mem_busy_o),
      .mem_done_o  (mem_done_o),
      .ram_req_o   (ram_req_o),
      .ram_we_o    (ram_we_o),
      .ram_addr_o  (ram_addr_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_wmask_o (ram_wmask_o),
      .ram_rdata_i (ram_rdata_i),
      .ram_ack_i   (ram_ack_i)
   );

   int errors = 0;
   int checks = 0;
   int glog [$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic pend(input logic [1:0] rw);
      return (rw == 2'b01) || (rw == 2'b10);
   endfunction

   // RAM responder: acks after ram_delay waiting cycles, read data derived from address.
   int          ram_delay = 0;
   logic        rd_ovr_en = 1'b0;
   logic [31:0] rd_ovr    = '0;
   logic        stray_en  = 1'b0;

   initial begin
      int cnt;
      cnt         = 0;
      ram_ack_i   = 1'b0;
      ram_rdata_i = '0;
      forever begin
         @(posedge clk);
         #1;
         ram_ack_i = 1'b0;
         if (ram_req_o) begin
            if (cnt >= ram_delay) begin
               ram_ack_i   = 1'b1;
               ram_rdata_i = rd_ovr_en ? rd_ovr : (ram_addr_o ^ 32'h5A5A_0000);
               cnt         = 0;
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
            if (stray_en) begin
               ram_ack_i   = 1'b1;
               ram_rdata_i = 32'hBAD0_BAD0;
            end
         end
      end
   end

   // Transaction-level model checked on every falling edge.
   initial begin
      logic        m_last, m_out, m_ackd, m_ch, m_we, prev_req, is_new, exp_req;
      logic [31:0] m_addr, m_wd, m_rd;
      logic [3:0]  m_mask;
      logic [31:0] m_data [2];
      logic [1:0]  prev_done, prev_pend, pnow, exp_done;
      logic [1:0]  p_rw [2];
      logic [31:0] p_ad [2];
      logic [31:0] p_wd [2];
      logic [3:0]  p_sel [2];
      m_last = 1'b1; m_out = 1'b0; m_ackd = 1'b0; m_ch = 1'b0; m_we = 1'b0;
      m_addr = '0; m_wd = '0; m_rd = '0; m_mask = '0;
      prev_req = 1'b0; prev_done = '0; prev_pend = '0;
      for (int c = 0; c < 2; c++) begin
         m_data[c] = '0; p_rw[c] = '0; p_ad[c] = '0; p_wd[c] = '0; p_sel[c] = '0;
      end
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("rst_ram_ctl", 64'({ram_req_o, ram_we_o, ram_wmask_o}), 64'(0));
            chk("rst_ram_addr", 64'(ram_addr_o), 64'(0));
            chk("rst_ram_wdata", 64'(ram_wdata_o), 64'(0));
            chk("rst_busy_done", 64'({mem_busy_o, mem_done_o}), 64'(0));
            chk("rst_rdata", mem_data_o, 64'(0));
            m_last = 1'b1; m_out = 1'b0; m_ackd = 1'b0;
            prev_req = 1'b0; prev_done = '0; prev_pend = '0;
            m_data[0] = '0; m_data[1] = '0;
         end else begin
            pnow     = {pend(rw_q[1]), pend(rw_q[0])};
            exp_done = m_ackd ? (m_ch ? 2'b10 : 2'b01) : 2'b00;
            is_new   = !m_out && !prev_req && (prev_done == 2'b00) && (prev_pend != 2'b00);
            exp_req  = m_out || is_new;
            chk("ram_req", 64'(ram_req_o), 64'(exp_req));
            chk("done", 64'(mem_done_o), 64'(exp_done));
            if (exp_done != 2'b00) begin
               if (!m_we) m_data[m_ch] = m_rd;
               glog.push_back(int'(m_ch));
            end
            m_ackd = 1'b0;
            chk("busy", 64'(mem_busy_o), 64'(pnow & ~exp_done));
            chk("read_data", mem_data_o, {m_data[1], m_data[0]});
            if (is_new) begin
               m_ch   = (&prev_pend) ? ~m_last : prev_pend[1];
               m_last = m_ch;
               m_addr = p_ad[m_ch];
               m_we   = (p_rw[m_ch] == 2'b10);
               m_wd   = p_wd[m_ch];
               m_mask = p_sel[m_ch];
               m_out  = 1'b1;
            end
            if (m_out && ram_req_o) begin
               chk("ram_addr", 64'(ram_addr_o), 64'(m_addr));
               chk("ram_we", 64'(ram_we_o), 64'(m_we));
               chk("ram_wdata", 64'(ram_wdata_o), 64'(m_wd));
               chk("ram_wmask", 64'(ram_wmask_o), 64'(m_mask));
               if (ram_ack_i) begin
                  m_out  = 1'b0;
                  m_ackd = 1'b1;
                  m_rd   = ram_rdata_i;
               end
            end
            prev_req  = exp_req;
            prev_done = exp_done;
            prev_pend = pnow;
            for (int c = 0; c < 2; c++) begin
               p_rw[c] = rw_q[c]; p_ad[c] = ad_q[c]; p_wd[c] = wd_q[c]; p_sel[c] = sel_q[c];
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int c, input int budget);
      int n;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!mem_done_o[c] && n < budget);
      if (!mem_done_o[c]) begin
         checks++;
         errors++;
         $display("FAIL done_timeout ch%0d: no done within %0d cycles", c, budget);
      end
   endtask

   task automatic wait_req(input int budget);
      int n;
      n = 0;
      while (!ram_req_o && n < budget) begin
         tick(1);
         n++;
      end
      if (!ram_req_o) begin
         checks++;
         errors++;
         $display("FAIL req_timeout: ram_req_o not raised within %0d cycles", budget);
      end
   endtask

   task automatic chan_seq(input int c, input logic [31:0] base);
      for (int i = 0; i < 4; i++) begin
         rw_q[c] = 2'b01;
         ad_q[c] = base + 32'(i * 4);
         wait_done(c, 50);
      end
      rw_q[c] = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int s, rc, dc;
      for (int c = 0; c < 2; c++) begin
         rw_q[c] = 2'b00; ad_q[c] = '0; wd_q[c] = '0; sel_q[c] = '0;
      end

      // Reset held with ch0 reading; busy must stay low. Tie after release goes to ch0.
      rst = 1'b0;
      rw_q[0] = 2'b01; ad_q[0] = 32'h0000_0100;
      tick(3);
      chk("t1_busy_in_reset", 64'(mem_busy_o), 64'(0));
      rw_q[1] = 2'b01; ad_q[1] = 32'h0000_0800;
      rst = 1'b1;
      wait_done(0, 20);
      chk("t1_first_grant", 64'(mem_done_o), 64'(2'b01));
      chk("t1_ch0_data", 64'(mem_data_o[31:0]), 64'(32'h5A5A_0100));
      rw_q[0] = 2'b00;
      wait_done(1, 20);
      chk("t1_ch1_data", 64'(mem_data_o[63:32]), 64'(32'h5A5A_0800));
      rw_q[1] = 2'b00;
      tick(2);

      // Single I-cache read.
      rd_ovr_en = 1'b1; rd_ovr = 32'hDEAD_BEEF;
      rw_q[1] = 2'b01; ad_q[1] = 32'h0000_1000;
      wait_done(1, 20);
      chk("t2_ch1_data", 64'(mem_data_o[63:32]), 64'(32'hDEAD_BEEF));
      chk("t2_ch0_untouched", 64'(mem_data_o[31:0]), 64'(32'h5A5A_0100));
      rw_q[1] = 2'b00;
      tick(1);
      chk("t2_done_one_cycle", 64'(mem_done_o), 64'(0));
      rd_ovr_en = 1'b0;
      tick(2);

      // D-cache write.
      rw_q[0] = 2'b10; ad_q[0] = 32'h0000_0040; wd_q[0] = 32'h1234_5678; sel_q[0] = 4'b0011;
      wait_req(10);
      chk("t3_we", 64'(ram_we_o), 64'(1));
      chk("t3_mask", 64'(ram_wmask_o), 64'(4'b0011));
      chk("t3_addr", 64'(ram_addr_o), 64'(32'h0000_0040));
      chk("t3_wdata", 64'(ram_wdata_o), 64'(32'h1234_5678));
      wait_done(0, 20);
      chk("t3_rdata_kept", 64'(mem_data_o[31:0]), 64'(32'h5A5A_0100));
      rw_q[0] = 2'b00;
      tick(2);

      // Contention: last grant was ch0, so ch1 wins the first tie, then strict alternation.
      s = glog.size();
      fork
         chan_seq(0, 32'h0000_0200);
         chan_seq(1, 32'h0000_0300);
      join
      tick(2);
      chk("t4_grant_count", 64'(glog.size() - s), 64'(8));
      for (int i = 0; i < 8 && (s + i) < glog.size(); i++) begin
         chk("t4_grant_order", 64'(glog[s + i]), 64'((i % 2 == 0) ? 1 : 0));
      end

      // Slow RAM: 7 waiting cycles before the ack cycle.
      ram_delay = 7;
      rw_q[1] = 2'b01; ad_q[1] = 32'h0000_2000;
      rc = 0; s = 0;
      do begin
         tick(1);
         s++;
         if (ram_req_o) rc++;
      end while (!mem_done_o[1] && s < 40);
      chk("t5_done_seen", 64'(mem_done_o), 64'(2'b10));
      chk("t5_req_cycles", 64'(rc), 64'(8));
      chk("t5_ch1_data", 64'(mem_data_o[63:32]), 64'(32'h5A5A_2000));
      rw_q[1] = 2'b00;
      ram_delay = 0;
      tick(2);

      // Reset mid-ISSUE, then an illegal 2'b11 request and stray acks while idle.
      ram_delay = 5;
      rw_q[0] = 2'b01; ad_q[0] = 32'h0000_0080;
      wait_req(10);
      tick(2);
      rst = 1'b0;
      #1;
      chk("t6_req_drop", 64'(ram_req_o), 64'(0));
      chk("t6_busy_drop", 64'(mem_busy_o), 64'(0));
      rw_q[0] = 2'b00; rw_q[1] = 2'b11;
      tick(2);
      rst = 1'b1;
      rc = 0; dc = 0;
      for (int i = 0; i < 12; i++) begin
         stray_en = (i >= 3 && i < 6);
         tick(1);
         if (ram_req_o) rc++;
         if (mem_done_o != 2'b00) dc++;
      end
      stray_en = 1'b0;
      chk("t6_no_req", 64'(rc), 64'(0));
      chk("t6_no_done", 64'(dc), 64'(0));
      chk("t6_rdata_cleared", mem_data_o, 64'(0));
      rw_q[1] = 2'b00;
      ram_delay = 0;
      tick(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
